// File: rtl/interval_meter_pkg.sv
// interval_meter shared definitions
// state encoding and counter range helper
package interval_meter_pkg;

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_COUNTING = 1'b1;

    typedef enum logic {
        IDLE     = ST_IDLE,
        COUNTING = ST_COUNTING
    } state_t;

    function automatic int unsigned max_cycles(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/interval_meter.sv
// interval_meter: start/stop interval measurement
// reports cycles and ns, saturates with overflow flag
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int CLOCK_CYCLE_TIME = 10,
    parameter int COUNT_WIDTH      = 16,
    parameter int TIME_WIDTH       = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   valid,
    output logic [COUNT_WIDTH-1:0] elapsed_cycles,
    output logic [TIME_WIDTH-1:0]  elapsed_time,
    output logic                   overflow
);

    localparam logic [COUNT_WIDTH-1:0] MAX_CYCLES =
        COUNT_WIDTH'(max_cycles(COUNT_WIDTH));
    localparam int PW = COUNT_WIDTH + 32;

    state_t                 state, state_nx;
    logic [COUNT_WIDTH-1:0] count, count_nx;
    logic                   load;
    logic                   ovf_nx;
    logic [COUNT_WIDTH-1:0] ld_val;
    logic [PW-1:0]          prod;

    assign busy = (state == COUNTING);
    assign prod = PW'(ld_val) * PW'(CLOCK_CYCLE_TIME);

    // state and cycle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // next state, counter update and result load decision
    always_comb begin
        state_nx = state;
        count_nx = count;
        load     = 1'b0;
        ovf_nx   = 1'b0;
        ld_val   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = COUNTING;
                    count_nx = '0;
                end
            end
            COUNTING: begin
                if (count == MAX_CYCLES) begin
                    load     = 1'b1;
                    ovf_nx   = 1'b1;
                    ld_val   = MAX_CYCLES;
                    state_nx = IDLE;
                end else if (stop) begin
                    load     = 1'b1;
                    ld_val   = count + 1'b1;
                    state_nx = IDLE;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // registered results, held until the next measurement completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid          <= 1'b0;
            elapsed_cycles <= '0;
            elapsed_time   <= '0;
            overflow       <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                elapsed_cycles <= ld_val;
                elapsed_time   <= TIME_WIDTH'(prod);
                overflow       <= ovf_nx;
            end
        end
    end

endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: directed checks of interval_meter
// 8-bit and 4-bit counter instances share stimulus
module tb_interval_meter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;

    logic        busy8, valid8, ovf8;
    logic [7:0]  cyc8;
    logic [15:0] time8;

    logic        busy4, valid4, ovf4;
    logic [3:0]  cyc4;
    logic [11:0] time4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   gap;
        int   exp_cyc;
        int   exp_time;
        logic exp_ovf;
    } vec_t;

    vec_t vecs[6];

    interval_meter #(
        .CLOCK_CYCLE_TIME(10),
        .COUNT_WIDTH(8),
        .TIME_WIDTH(16)
    ) dut8 (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .busy(busy8),
        .valid(valid8),
        .elapsed_cycles(cyc8),
        .elapsed_time(time8),
        .overflow(ovf8)
    );

    interval_meter #(
        .CLOCK_CYCLE_TIME(10),
        .COUNT_WIDTH(4),
        .TIME_WIDTH(12)
    ) dut4 (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .busy(busy4),
        .valid(valid4),
        .elapsed_cycles(cyc4),
        .elapsed_time(time4),
        .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic measure(input int gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (gap - 1) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        vecs[0] = '{gap: 3,   exp_cyc: 3,   exp_time: 30,   exp_ovf: 1'b0};
        vecs[1] = '{gap: 1,   exp_cyc: 1,   exp_time: 10,   exp_ovf: 1'b0};
        vecs[2] = '{gap: 2,   exp_cyc: 2,   exp_time: 20,   exp_ovf: 1'b0};
        vecs[3] = '{gap: 100, exp_cyc: 100, exp_time: 1000, exp_ovf: 1'b0};
        vecs[4] = '{gap: 255, exp_cyc: 255, exp_time: 2550, exp_ovf: 1'b0};
        vecs[5] = '{gap: 256, exp_cyc: 255, exp_time: 2550, exp_ovf: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        chk("rst_busy", int'(busy8), 0);
        chk("rst_valid", int'(valid8), 0);
        chk("rst_cycles", int'(cyc8), 0);
        chk("rst_time", int'(time8), 0);
        chk("rst_ovf", int'(ovf8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            reset_all();
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("vec_busy_start", int'(busy8), 1);
            repeat (vecs[i].gap - 1) tick();
            chk("vec_busy_pre", int'(busy8), 1);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk("vec_valid", int'(valid8), 1);
            chk("vec_cycles", int'(cyc8), vecs[i].exp_cyc);
            chk("vec_time", int'(time8), vecs[i].exp_time);
            chk("vec_ovf", int'(ovf8), int'(vecs[i].exp_ovf));
            chk("vec_busy_end", int'(busy8), 0);
            tick();
            chk("vec_valid_1cyc", int'(valid8), 0);
            chk("vec_hold", int'(cyc8), vecs[i].exp_cyc);
        end

        // start and stop together in IDLE, then stop next edge
        reset_all();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        chk("min_busy", int'(busy8), 1);
        chk("min_novalid", int'(valid8), 0);
        tick();
        stop = 1'b0;
        chk("min_valid", int'(valid8), 1);
        chk("min_cycles", int'(cyc8), 1);
        chk("min_time", int'(time8), 10);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stray_valid", int'(valid8), 0);
        chk("stray_busy", int'(busy8), 0);
        chk("stray_hold", int'(cyc8), 1);

        // second start while counting is ignored
        reset_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("restart_valid", int'(valid8), 1);
        chk("restart_cycles", int'(cyc8), 7);

        // asynchronous reset mid-measurement
        measure(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        chk("arst_busy", int'(busy8), 0);
        chk("arst_cycles", int'(cyc8), 0);
        chk("arst_time", int'(time8), 0);
        chk("arst_valid", int'(valid8), 0);
        #13;
        rst_n = 1'b1;
        tick();
        chk("arst_novalid", int'(valid8), 0);
        chk("arst_idle", int'(busy8), 0);
        measure(2);
        chk("arst_after", int'(cyc8), 2);

        // back-to-back: start accepted in the valid cycle
        reset_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("b2b_valid1", int'(valid8), 1);
        chk("b2b_cycles1", int'(cyc8), 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", int'(busy8), 1);
        chk("b2b_valid_low", int'(valid8), 0);
        repeat (3) tick();
        chk("b2b_hold", int'(cyc8), 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("b2b_valid2", int'(valid8), 1);
        chk("b2b_cycles2", int'(cyc8), 4);
        chk("b2b_time2", int'(time8), 40);

        // saturation on the 4-bit instance
        reset_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        chk("ovf_not_yet", int'(valid4), 0);
        chk("ovf_busy_pre", int'(busy4), 1);
        tick();
        chk("ovf_valid", int'(valid4), 1);
        chk("ovf_flag", int'(ovf4), 1);
        chk("ovf_cycles", int'(cyc4), 15);
        chk("ovf_time", int'(time4), 150);
        chk("ovf_busy", int'(busy4), 0);
        tick();
        chk("ovf_hold", int'(ovf4), 1);

        reset_all();
        measure(15);
        chk("edge15_valid", int'(valid4), 1);
        chk("edge15_cycles", int'(cyc4), 15);
        chk("edge15_ovf", int'(ovf4), 0);
        chk("edge15_time", int'(time4), 150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
